// File: rtl/global_pkg.sv
// Shared types and constants for the RAM arbiter slice.
// Holds the arbiter state/owner enums and the RAM idle levels.
package global_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPU_OWN,
    DMA_OWN,
    SWITCH
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } arb_owner_t;

  localparam logic RAM_OEN_IDLE = 1'b1;
  localparam logic RAM_CS_IDLE  = 1'b0;

endpackage

// File: rtl/ram_arb_mux.sv
// Combinational owner select for the shared RAM bus and read data.
// Ports: owner code in, CPU/DMA bus in, RAM_* out, per-master Rdata out.
module ram_arb_mux
  import global_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic [1:0]        owner,
  input  logic [ADDR_W-1:0] Cpu_Addr,
  input  logic              Cpu_Cs,
  input  logic              Cpu_Wen,
  input  logic              Cpu_Oen,
  input  logic [DATA_W-1:0] Cpu_Wdata,
  output logic [DATA_W-1:0] Cpu_Rdata,
  input  logic [ADDR_W-1:0] Dma_Addr,
  input  logic              Dma_Cs,
  input  logic              Dma_Wen,
  input  logic              Dma_Oen,
  input  logic [DATA_W-1:0] Dma_Wdata,
  output logic [DATA_W-1:0] Dma_Rdata,
  output logic [ADDR_W-1:0] RAM_Addr,
  output logic              RAM_Cs,
  output logic              RAM_Wen,
  output logic              RAM_Oen,
  output logic [DATA_W-1:0] RAM_Wdata,
  input  logic [DATA_W-1:0] RAM_Rdata
);

  always_comb begin
    RAM_Addr  = '0;
    RAM_Cs    = RAM_CS_IDLE;
    RAM_Wen   = 1'b0;
    RAM_Oen   = RAM_OEN_IDLE;
    RAM_Wdata = '0;
    Cpu_Rdata = '0;
    Dma_Rdata = '0;
    unique case (1'b1)
      (owner == OWN_CPU): begin
        RAM_Addr  = Cpu_Addr;
        RAM_Cs    = Cpu_Cs;
        RAM_Wen   = Cpu_Wen;
        RAM_Oen   = Cpu_Oen;
        RAM_Wdata = Cpu_Wdata;
        Cpu_Rdata = RAM_Rdata;
      end
      (owner == OWN_DMA): begin
        RAM_Addr  = Dma_Addr;
        RAM_Cs    = Dma_Cs;
        RAM_Wen   = Dma_Wen;
        RAM_Oen   = Dma_Oen;
        RAM_Wdata = Dma_Wdata;
        Dma_Rdata = RAM_Rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master (CPU/DMA) RAM arbiter with registered grants and DMA burst cap.
// Ports: Clk/Rst, per-master Req/Gnt and bus, Dma_Preempt, RAM_* bus.
module ram_arbiter
  import global_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int MAX_DMA_BURST = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Cpu_Req,
  output logic              Cpu_Gnt,
  input  logic [ADDR_W-1:0] Cpu_Addr,
  input  logic              Cpu_Cs,
  input  logic              Cpu_Wen,
  input  logic              Cpu_Oen,
  input  logic [DATA_W-1:0] Cpu_Wdata,
  output logic [DATA_W-1:0] Cpu_Rdata,
  input  logic              Dma_Req,
  output logic              Dma_Gnt,
  input  logic [ADDR_W-1:0] Dma_Addr,
  input  logic              Dma_Cs,
  input  logic              Dma_Wen,
  input  logic              Dma_Oen,
  input  logic [DATA_W-1:0] Dma_Wdata,
  output logic [DATA_W-1:0] Dma_Rdata,
  output logic              Dma_Preempt,
  output logic [ADDR_W-1:0] RAM_Addr,
  output logic              RAM_Cs,
  output logic              RAM_Wen,
  output logic              RAM_Oen,
  output logic [DATA_W-1:0] RAM_Wdata,
  input  logic [DATA_W-1:0] RAM_Rdata
);

  localparam int CNT_W =
    (MAX_DMA_BURST > 1) ? $clog2(MAX_DMA_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MAX_DMA_BURST - 1);

  arb_state_t       state_q, state_d;
  arb_owner_t       tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       owner;
  logic             cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      tgt_q   <= OWN_NONE;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (Dma_Req)      state_d = DMA_OWN;
        else if (Cpu_Req) state_d = CPU_OWN;
      end
      CPU_OWN: begin
        if (!Cpu_Req) begin
          if (Dma_Req) begin
            state_d = SWITCH;
            tgt_d   = OWN_DMA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DMA_OWN: begin
        if (!Dma_Req) begin
          if (Cpu_Req) begin
            state_d = SWITCH;
            tgt_d   = OWN_CPU;
          end else begin
            state_d = IDLE;
          end
        end else if (Cpu_Req && cnt_last) begin
          state_d = SWITCH;
          tgt_d   = OWN_CPU;
        end
      end
      SWITCH: begin
        // Target gets first claim; otherwise fall back to the other master.
        if (tgt_q == OWN_CPU) begin
          if (Cpu_Req)      state_d = CPU_OWN;
          else if (Dma_Req) state_d = DMA_OWN;
          else              state_d = IDLE;
        end else begin
          if (Dma_Req)      state_d = DMA_OWN;
          else if (Cpu_Req) state_d = CPU_OWN;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst length only accrues while the CPU is actually waiting.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (state_d == DMA_OWN && state_q != DMA_OWN) begin
      cnt_q <= '0;
    end else if (state_q == DMA_OWN && Cpu_Req && !cnt_last) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    Cpu_Gnt     = (state_q == CPU_OWN);
    Dma_Gnt     = (state_q == DMA_OWN);
    Dma_Preempt = (state_q == DMA_OWN) && Dma_Req
                  && Cpu_Req && cnt_last;
    owner       = OWN_NONE;
    if (state_q == CPU_OWN)      owner = OWN_CPU;
    else if (state_q == DMA_OWN) owner = OWN_DMA;
  end

  ram_arb_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .owner     (owner),
    .Cpu_Addr  (Cpu_Addr),
    .Cpu_Cs    (Cpu_Cs),
    .Cpu_Wen   (Cpu_Wen),
    .Cpu_Oen   (Cpu_Oen),
    .Cpu_Wdata (Cpu_Wdata),
    .Cpu_Rdata (Cpu_Rdata),
    .Dma_Addr  (Dma_Addr),
    .Dma_Cs    (Dma_Cs),
    .Dma_Wen   (Dma_Wen),
    .Dma_Oen   (Dma_Oen),
    .Dma_Wdata (Dma_Wdata),
    .Dma_Rdata (Dma_Rdata),
    .RAM_Addr  (RAM_Addr),
    .RAM_Cs    (RAM_Cs),
    .RAM_Wen   (RAM_Wen),
    .RAM_Oen   (RAM_Oen),
    .RAM_Wdata (RAM_Wdata),
    .RAM_Rdata (RAM_Rdata)
  );

endmodule
